// File: rtl/memctrl_ext_if.sv
`default_nettype none
// ============================================================================
//  Module      : memctrl_ext_if
//  Description : AVR CPU data-bus bundle between the core (master) and the
//                memory controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface memctrl_ext_if;
   logic [15:0] address;
   logic        rden;
   logic        wren;
   logic [7:0]  data_o;
   logic [7:0]  data_i;
   logic        cpu_ready;

   modport master (
      output address, rden, wren, data_o,
      input  data_i, cpu_ready
   );

   modport slave (
      input  address, rden, wren, data_o,
      output data_i, cpu_ready
   );
endinterface
`default_nettype wire

// File: rtl/memctrl_ext.sv
`default_nettype none
// ============================================================================
//  Module      : memctrl_ext
//  Description : AVR data-bus router and I/O register file. A banked window
//                at the top of data space is routed to TEXT memory, dropped
//                (unmapped), or sent over a req/ack external channel that
//                stalls the CPU. Hosts bank, status and NPORTS port registers.
//                Optional external channel enabled by macro MEMCTRL_EXT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module memctrl_ext #(
   parameter logic [15:0] WIN_BASE  = 16'hF000,
   parameter logic [15:0] BANK_ADDR = 16'h0020,
   parameter logic [15:0] STAT_ADDR = 16'h0021,
   parameter logic [15:0] PORT_BASE = 16'h002C,
   parameter int          NPORTS    = 2,
   parameter logic [7:0]  TEXT_LO   = 8'h02,
   parameter logic [7:0]  TEXT_HI   = 8'h03,
   parameter logic [7:0]  EXT_LO    = 8'h80,
   parameter int          TIMEOUT   = 64
) (
   input  wire logic              clock,
   input  wire logic              reset_n,
   memctrl_ext_if.slave           bus,
   output logic [7:0]             bank,
   input  wire logic [7:0]        data_o_sram,
   input  wire logic [7:0]        data_o_text,
   output logic                   data_w_sram,
   output logic                   data_w_text,
   output logic [8*NPORTS-1:0]    port_out,
   output logic                   ext_req,
   output logic                   ext_we,
   output logic [19:0]            ext_addr,
   output logic [7:0]             ext_wdata,
   input  wire logic [7:0]        ext_rdata,
   input  wire logic              ext_ack
);

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic                    w_in_win;
   logic                    w_is_text;
   logic                    w_bank_hit;
   logic                    w_stat_hit;
   logic                    w_reg_wr;
   logic [11:0]             w_offset;
   logic [NPORTS-1:0]       w_port_sel;
   logic [NPORTS-1:0][7:0]  w_port_term;
   logic [7:0]              w_port_rd;
   logic [7:0]              w_status;
   logic [7:0]              w_route_data;
   logic [7:0]              r_bank;

   assign w_in_win   = (bus.address >= WIN_BASE);
   assign w_is_text  = (r_bank >= TEXT_LO) && (r_bank <= TEXT_HI);
   assign w_bank_hit = (bus.address == BANK_ADDR);
   assign w_stat_hit = (bus.address == STAT_ADDR);
   // Only the low 12 bits of the window offset reach the external address.
   assign w_offset   = bus.address[11:0] - WIN_BASE[11:0];
   // Registers only update when the CPU is not being stalled.
   assign w_reg_wr   = bus.wren && bus.cpu_ready;
   assign bank       = r_bank;

   // Bank register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_bank <= 8'h00;
      end else if (w_reg_wr && w_bank_hit) begin
         r_bank <= bus.data_o;
      end
   end

   // ------------------------------------------------------------------------
   // Port registers
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < NPORTS; k++) begin : g_port
      logic [7:0] r_port;

      assign w_port_sel[k]    = (bus.address == PORT_BASE + 16'(k));
      assign w_port_term[k]   = w_port_sel[k] ? r_port : 8'h00;
      assign port_out[8*k +: 8] = r_port;

      // Port register k, written through its own I/O address
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_port <= 8'h00;
         end else if (w_reg_wr && w_port_sel[k]) begin
            r_port <= bus.data_o;
         end
      end
   end

   // Merge the one-hot port read terms into a single byte
   always_comb begin
      w_port_rd = 8'h00;
      for (int k = 0; k < NPORTS; k++) begin
         w_port_rd = w_port_rd | w_port_term[k];
      end
   end

   // Route read data and write strobes; ext banks fall to the 8'hFF default
   always_comb begin
      w_route_data = data_o_sram;
      data_w_sram  = bus.wren;
      data_w_text  = 1'b0;
      if (w_in_win) begin
         data_w_sram = 1'b0;
         if (w_is_text) begin
            data_w_text  = bus.wren;
            w_route_data = data_o_text;
         end else begin
            w_route_data = 8'hFF;
         end
      end else if (w_bank_hit) begin
         w_route_data = r_bank;
      end else if (w_stat_hit) begin
         w_route_data = w_status;
      end else if (|w_port_sel) begin
         w_route_data = w_port_rd;
      end
   end

`ifdef MEMCTRL_EXT_EN
   // ------------------------------------------------------------------------
   // External channel FSM
   // ------------------------------------------------------------------------
   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_REQ  = 2'd1;
   localparam logic [1:0]    S_DONE = 2'd2;
   localparam int            CW     = $clog2(TIMEOUT);
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_rdata;
   logic          r_err;
   logic          r_ext_req;
   logic          r_ext_we;
   logic [19:0]   r_ext_addr;
   logic [7:0]    r_ext_wdata;
   logic          w_ext_acc;
   logic          w_ack;
   logic          w_tmo;
   logic          w_busy;
   logic          w_err_clr;

   // Gated by reset so a held strobe cannot stall the CPU during reset.
   assign w_ext_acc = reset_n && w_in_win && (r_bank >= EXT_LO) &&
                      (bus.rden || bus.wren);
   assign w_ack     = (r_state == S_REQ) && ext_ack;
   // Ack takes priority over an expiring counter.
   assign w_tmo     = (r_state == S_REQ) && !ext_ack && (r_cnt == C_LAST);
   assign w_err_clr = w_reg_wr && w_stat_hit && bus.data_o[0];
   assign w_status  = {6'b000000, w_busy, r_err};

   assign ext_req   = r_ext_req;
   assign ext_we    = r_ext_we;
   assign ext_addr  = r_ext_addr;
   assign ext_wdata = r_ext_wdata;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_ext_acc) w_next = S_REQ;
         S_REQ:   if (w_ack || w_tmo) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: stall while an ext access is pending, latched byte in DONE
   always_comb begin
      bus.cpu_ready = 1'b1;
      bus.data_i    = w_route_data;
      w_busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  bus.cpu_ready = !w_ext_acc;
         S_REQ:   bus.cpu_ready = 1'b0;
         S_DONE:  bus.data_i    = r_rdata;
         default: bus.cpu_ready = 1'b1;
      endcase
   end

   // Transaction capture, request line, wait counter and returned byte
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ext_req   <= 1'b0;
         r_ext_we    <= 1'b0;
         r_ext_addr  <= 20'h00000;
         r_ext_wdata <= 8'h00;
         r_cnt       <= '0;
         r_rdata     <= 8'h00;
      end else if (r_state == S_IDLE) begin
         if (w_ext_acc) begin
            r_ext_req   <= 1'b1;
            r_ext_we    <= bus.wren;
            r_ext_addr  <= {r_bank, w_offset};
            r_ext_wdata <= bus.data_o;
            r_cnt       <= '0;
         end
      end else if (r_state == S_REQ) begin
         if (w_ack) begin
            r_ext_req <= 1'b0;
            r_rdata   <= ext_rdata;
         end else if (w_tmo) begin
            r_ext_req <= 1'b0;
            r_rdata   <= 8'hFF;
         end else begin
            r_cnt <= r_cnt + C_ONE;
         end
      end
   end

   // Sticky error: timeout sets it, write-1 to bit0 clears, set wins
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (w_tmo) begin
         r_err <= 1'b1;
      end else if (w_err_clr) begin
         r_err <= 1'b0;
      end
   end
`else
   // External channel absent: ext banks read 8'hFF and never stall.
   logic w_unused_ext;

   assign w_unused_ext  = ^{ext_rdata, ext_ack};
   assign w_status      = 8'h00;
   assign bus.cpu_ready = 1'b1;
   assign bus.data_i    = w_route_data;
   assign ext_req       = 1'b0;
   assign ext_we        = 1'b0;
   assign ext_addr      = 20'h00000;
   assign ext_wdata     = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/memctrl_ext.md
# memctrl_ext

Parametrised AVR data-bus router and I/O register file: maps a banked window at the top of data space onto SRAM, TEXT memory, or an external slow memory channel, and hosts the bank, status and general port registers. Extends the fixed-map controller with a configurable window, N port registers, a req/ack external-memory channel with CPU stall, and a timeout with sticky error. Sits between the AVR core and the internal/external memories.

## Interface
- `WIN_BASE`, 16'hF000: first address of the banked window; window runs to 16'hFFFF, offset = `address - WIN_BASE`.
- `BANK_ADDR`, 16'h20: I/O address of the bank register.
- `STAT_ADDR`, 16'h21: I/O address of the status register.
- `PORT_BASE`, 16'h2C: address of port register 0; port k at `PORT_BASE+k`.
- `NPORTS`, 2: number of 8-bit port registers (1..16).
- `TEXT_LO`/`TEXT_HI`, 8'h02/8'h03: inclusive bank range routed to TEXT memory.
- `EXT_LO`, 8'h80: banks >= `EXT_LO` routed to the external channel.
- `TIMEOUT`, 64: cycles `ext_req` may wait for `ext_ack` (>= 2).
- `clock` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 16: CPU data address.
- `rden`, `wren` in 1: CPU read / write strobes, held while `cpu_ready`=0.
- `data_o` in 8: write data from CPU.
- `data_i` out 8: read data to CPU.
- `cpu_ready` out 1: 0 stalls the CPU.
- `bank` out 8: bank register.
- `data_o_sram`, `data_o_text` in 8; `data_w_sram`, `data_w_text` out 1: internal memories.
- `port_out` out 8*NPORTS: port k in bits [8k+7:8k].
- `ext_req` out 1, `ext_we` out 1, `ext_addr` out 20, `ext_wdata` out 8, `ext_rdata` in 8, `ext_ack` in 1: external channel.

## Operation
- Outside window: `data_i` = `data_o_sram`, `data_w_sram` = `wren`, except reads at `BANK_ADDR`, `STAT_ADDR`, port addresses return the register (SRAM write still passes through, as before).
- Window, bank in TEXT range: `data_w_text`=`wren`, `data_w_sram`=0, `data_i`=`data_o_text`; zero wait.
- Window, unmapped bank: reads 8'hFF, writes dropped, zero wait.
- Window, bank >= `EXT_LO`: external transaction (see Configuration).
- Status: bit0 `err` sticky (set on timeout, cleared by writing 1 to bit0), bit1 `busy` (FSM not IDLE), bits 7:2 read 0.
- Register writes at rising edge when `wren` and `cpu_ready`.
- FSM: IDLE -> REQ on (rden|wren) to ext bank; latches `ext_addr`={bank[7:0], offset[11:0]}, `ext_we`=wren, `ext_wdata`=data_o; counter cleared. REQ -> DONE on `ext_ack` (latch `ext_rdata`) or counter = TIMEOUT-1 (latch 8'hFF, set `err`). DONE -> IDLE unconditionally.
- `ext_ack` and timeout same cycle: ack wins, `err` unchanged.
- Write-1-to-clear of `err` and timeout same cycle: set wins.

## Timing
- Reset: bank=0, ports=0, err=0, FSM IDLE, `ext_req`=0, `ext_we`=0, `ext_addr`=0, `ext_wdata`=0; `cpu_ready`=1; `data_i` follows routing.
- `cpu_ready`=0 combinationally in the IDLE cycle an ext access is presented, and throughout REQ; 1 in DONE and for all non-ext accesses.
- `ext_req` registered: high from cycle after detection until the edge sampling `ext_ack`; deasserts next cycle. Minimum stall 2 cycles (ack in first REQ cycle); maximum TIMEOUT+1.
- In DONE, `data_i` = latched byte; CPU completes at that edge.
- `reset_n` asserted mid-REQ: `ext_req` drops immediately, no `err`.

## Configuration
- `MEMCTRL_EXT_EN` defined: external channel, FSM, timeout and `err` present as above.
- Undefined: banks >= `EXT_LO` behave as unmapped (8'hFF, writes dropped), `cpu_ready` tied 1, `ext_req`/`ext_we` tied 0, `ext_addr`/`ext_wdata` 0, status reads 8'h00.

## Test plan
- Reset, read 16'h20/16'h2C/16'h2D -> 8'h00; write 8'h5A to 16'h2D -> `port_out[15:8]`=8'h5A, read back 8'h5A.
- bank=8'h02, write 8'h11 to 16'hF010 -> `data_w_text`=1, `data_w_sram`=0, same cycle; bank=8'h05 read 16'hF000 -> 8'hFF, `cpu_ready`=1.
- bank=8'h81, read 16'hF123, ack after 3 cycles with 8'hC3 -> `ext_addr`=20'h81123, `ext_we`=0, stall 4 cycles, `data_i`=8'hC3 in DONE.
- bank=8'h90, write 8'h77, ack in first REQ cycle -> `ext_we`=1, `ext_wdata`=8'h77, stall exactly 2 cycles.
- No ack -> DONE after TIMEOUT cycles in REQ, read 8'hFF, status=8'h01; write 8'h01 to 16'h21 -> status 8'h00.
- `reset_n` low during REQ -> `ext_req`=0 immediately, `cpu_ready`=1, status 8'h00 after release.
